// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: one-cycle request out, one-cycle ack pulse back.
interface if_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: at most one outstanding memory request feeding a 2-entry
// {pc, instruction} FIFO whose head drives the IF/ID register.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           redirect,
    input  logic [15:0]    branch_target,
    if_stage_if.master     imem,
    output logic [15:0]    pc,
    output logic [15:0]    instruction,
    output logic           if_valid
);

    typedef enum logic [1:0] {StRun, StWait, StDiscard} state_e;

    state_e           state_q, state_d;
    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic [1:0]       count_q, count_d;
    logic [1:0][15:0] ent_pc_q, ent_pc_d;
    logic [1:0][15:0] ent_ins_q, ent_ins_d;
    logic             req, push, pop, outstanding;
    logic [15:0]      push_pc;

    // A request is still in flight after this edge unless its ack lands now.
    assign outstanding = (state_q != StRun) && !imem.imem_ack;

    assign if_valid    = (count_q != 2'd0);
    assign pc          = if_valid ? ent_pc_q[0] : 16'h0000;
    assign instruction = if_valid ? ent_ins_q[0] : NOP;

    assign req            = (state_q == StRun) && (count_q < 2'd2) && !redirect && !reset;
    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;
    assign pop            = if_valid && !stall && !redirect;
    // fetch_pc already advanced past the live request when it was issued.
    assign push_pc        = fetch_pc_q - 16'd2;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        ent_pc_d   = ent_pc_q;
        ent_ins_d  = ent_ins_q;
        push       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (req) begin
                    state_d    = StWait;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                end
            end
            StWait: begin
                if (imem.imem_ack) begin
                    state_d = StRun;
                    push    = 1'b1;
                end
            end
            StDiscard: begin
                if (imem.imem_ack) state_d = StRun;
            end
            default: state_d = StRun;
        endcase

        // A push only ever meets count <= 1, so the FIFO cannot overflow.
        if (pop && push) begin
            ent_pc_d[0]  = push_pc;
            ent_ins_d[0] = imem.imem_rdata;
        end else if (pop) begin
            ent_pc_d[0]  = ent_pc_q[1];
            ent_ins_d[0] = ent_ins_q[1];
            count_d      = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                ent_pc_d[0]  = push_pc;
                ent_ins_d[0] = imem.imem_rdata;
            end else begin
                ent_pc_d[1]  = push_pc;
                ent_ins_d[1] = imem.imem_rdata;
            end
            count_d = count_q + 2'd1;
        end

        if (redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = branch_target;
            state_d    = outstanding ? StDiscard : StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= outstanding ? StDiscard : StRun;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
        end
        ent_pc_q  <= ent_pc_d;
        ent_ins_q <= ent_ins_d;
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: randomized memory latency, stalls, redirects and resets, checked
// every cycle against a transaction-level queue model, plus directed literal pins.
module tb_if_stage;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP_W  = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] pc, instruction;
    logic        if_valid;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .branch_target(branch_target),
        .imem         (bus),
        .pc           (pc),
        .instruction  (instruction),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: latency >= 1 cycle, one request at a time.
    bit          mem_busy = 0;
    int          mem_wait = 0;
    int          lat_lo = 0, lat_hi = 0;
    bit          mem_fixed = 1;

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
    end

    always @(negedge clk) begin
        if (bus.imem_req) begin
            mem_busy = 1;
            mem_wait = $urandom_range(lat_hi, lat_lo);
        end
    end

    always @(posedge clk) begin
        #1;
        bus.imem_ack = 1'b0;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_fixed ? 16'hAAAA : 16'($urandom);
                mem_busy       = 0;
            end else begin
                mem_wait--;
            end
        end
    end

    // Reference model: queue of fetched {pc, word}, next fetch address, one pending slot.
    logic [31:0] m_fifo[$];
    logic [15:0] m_fetch = 16'h0000;
    logic [15:0] m_pend_addr = 16'h0000;
    bit          m_pend = 0, m_stale = 0, chk_en = 0;

    always @(posedge clk) begin
        bit had_pend;
        int sz;
        if (reset || redirect) begin
            m_fifo.delete();
            m_fetch = reset ? RST_PC : branch_target;
            if (m_pend && !bus.imem_ack) m_stale = 1;
            else m_pend = 0;
            if (reset) chk_en = 1;
        end else begin
            had_pend = m_pend;
            sz       = m_fifo.size();
            if (sz > 0 && !stall) void'(m_fifo.pop_front());
            if (had_pend && bus.imem_ack) begin
                if (!m_stale) m_fifo.push_back({m_pend_addr, bus.imem_rdata});
                m_pend = 0;
            end else if (!had_pend && sz < 2) begin
                m_pend      = 1;
                m_stale     = 0;
                m_pend_addr = m_fetch;
                m_fetch     = m_fetch + 16'd2;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] head;
        bit          exp_req;
        if (chk_en) begin
            head = (m_fifo.size() != 0) ? m_fifo[0] : {16'h0000, NOP_W};
            check("if_valid", {15'b0, if_valid}, {15'b0, m_fifo.size() != 0});
            check("pc", pc, head[31:16]);
            check("instruction", instruction, head[15:0]);
            exp_req = !reset && !redirect && !m_pend && m_fifo.size() < 2;
            check("imem_req", {15'b0, bus.imem_req}, {15'b0, exp_req});
            if (exp_req) check("imem_addr", bus.imem_addr, m_fetch);
        end
    end

    // Directed observation: issued addresses and popped {pc, instruction}.
    logic [15:0] aq[$];
    logic [15:0] vq[$];
    logic [15:0] iq[$];

    task automatic observe(input int cyc);
        aq.delete(); vq.delete(); iq.delete();
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (bus.imem_req) aq.push_back(bus.imem_addr);
            if (if_valid && !stall && !redirect) begin
                vq.push_back(pc);
                iq.push_back(instruction);
            end
        end
    endtask

    function automatic logic [15:0] qget(input logic [15:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 16'hxxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) tick();
        // Reset release, 1-cycle memory returning AAAA.
        reset = 1'b0;
        observe(12);
        check("p1_addr0", qget(aq, 0), 16'h0000);
        check("p1_addr1", qget(aq, 1), 16'h0002);
        check("p1_addr2", qget(aq, 2), 16'h0004);
        check("p1_first_pc", qget(vq, 0), 16'h0000);
        check("p1_first_ins", qget(iq, 0), 16'hAAAA);

        // Stall for 3 cycles: head held at 000A, FIFO fills, request drops.
        tick();
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_pc", pc, 16'h000A);
        end
        check("stall_full_req", {15'b0, bus.imem_req}, 16'd0);
        check("stall_valid", {15'b0, if_valid}, 16'd1);
        tick();
        stall = 1'b0;
        observe(8);
        check("rel_pc0", qget(vq, 0), 16'h000A);
        check("rel_pc1", qget(vq, 1), 16'h000C);
        check("rel_pc2", qget(vq, 2), 16'h000E);

        // Wrap at FFFE.
        mem_fixed = 0;
        tick();
        redirect = 1'b1; branch_target = 16'hFFFE;
        tick();
        redirect = 1'b0;
        observe(10);
        check("wrap_addr0", qget(aq, 0), 16'hFFFE);
        check("wrap_addr1", qget(aq, 1), 16'h0000);

        // Redirect with a request outstanding, late ack.
        lat_lo = 4; lat_hi = 4;
        for (int i = 0; i < 10 && !mem_busy; i++) tick();
        check("p4_outstanding", {15'b0, mem_busy}, 16'd1);
        redirect = 1'b1; branch_target = 16'h0100;
        tick();
        redirect = 1'b0; lat_lo = 0; lat_hi = 0;
        observe(20);
        check("p4_addr", qget(aq, 0), 16'h0100);
        check("p4_pc", qget(vq, 0), 16'h0100);

        // Redirect in the same cycle as an ack; odd target passes through.
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 10 && !bus.imem_ack; i++) tick();
        check("p5_ack_seen", {15'b0, bus.imem_ack}, 16'd1);
        redirect = 1'b1; branch_target = 16'h0201;
        tick();
        redirect = 1'b0;
        observe(20);
        check("p5_addr", qget(aq, 0), 16'h0201);
        check("p5_pc", qget(vq, 0), 16'h0201);

        // Reset with a request outstanding and the FIFO occupied.
        lat_lo = 6; lat_hi = 6; stall = 1'b1;
        for (int i = 0; i < 30 && !(mem_busy && m_fifo.size() >= 1); i++) tick();
        check("p6_setup", {15'b0, mem_busy && m_fifo.size() >= 1}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("p6_valid", {15'b0, if_valid}, 16'd0);
        check("p6_nop", instruction, NOP_W);
        check("p6_pc", pc, 16'h0000);
        lat_lo = 0; lat_hi = 0;
        observe(20);
        check("p6_addr", qget(aq, 0), RST_PC);
        check("p6_first_pc", qget(vq, 0), RST_PC);

        // Random traffic.
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall         = ($urandom_range(9, 0) < 3);
            redirect      = ($urandom_range(19, 0) == 0);
            branch_target = 16'($urandom);
            reset         = ($urandom_range(199, 0) == 0);
        end
        tick();
        stall = 1'b0; redirect = 1'b0; reset = 1'b0;
        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
